// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and constants for the fetch path.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return a & ~WORD_W'(3);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-unit bus: ROM address/data, fetch control, redirect and decode handshake.
interface ifetch_ctrl_if #(
  parameter int unsigned DEPTH = 4
) ();
  import cpu_pkg::*;

  logic [WORD_W-1:0]      rom_addr;
  logic [WORD_W-1:0]      rom_data;
  logic                   fetch_en;
  logic                   redirect_valid;
  logic [WORD_W-1:0]      redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_W-1:0]      out_instr;
  logic [WORD_W-1:0]      out_pc;
  logic [WORD_W-1:0]      out_pc4;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc, out_pc4, fifo_count,
    input  rom_data, fetch_en, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc, out_pc4, fifo_count,
    output rom_data, fetch_en, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry prefetch queue of {pc, instr}; flush clears it, push+pop allowed when full.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // When full, push and pop hit the same slot; the head leaves as it is overwritten.
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, fills the prefetch queue from the
// combinational ROM and presents the queue head to decode.
module ifetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_VECTOR
) (
  input logic          clk,
  input logic          reset,
  ifetch_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              enq;
  logic              deq;
  logic              out_valid;
  logic [CW-1:0]     count;
  fetch_entry_t      head;
  fetch_entry_t      wentry;

  assign out_valid = (count != '0);

  always_comb begin
    deq  = out_valid & bus.out_ready;
    enq  = bus.fetch_en & ~bus.redirect_valid & ((count < CW'(DEPTH)) | deq);
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = word_align(bus.redirect_pc);
    end else if (enq) begin
      pc_d = pc_q + WORD_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign wentry = '{pc: word_align(pc_q), instr: bus.rom_data};

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (enq),
    .pop   (deq),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign bus.rom_addr   = word_align(pc_q);
  assign bus.out_valid  = out_valid;
  assign bus.out_instr  = head.instr;
  assign bus.out_pc     = head.pc;
  // Gated so the empty-after-reset state reads as all zeros rather than 4.
  assign bus.out_pc4    = out_valid ? head.pc + WORD_W'(4) : '0;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_ifetch_ctrl;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  ifetch_ctrl_if #(.DEPTH(DEPTH)) bus ();

  ifetch_ctrl #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return ((a ^ 32'hDEAD_BEEF) * 32'h0001_0003) + 32'h0000_1234;
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of fetched entries and a fetch PC.
  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  bit           started = 0;
  bit           just_rst = 0;

  always @(posedge clk) begin
    bit m_deq, m_enq;
    if (reset) begin
      mq.delete();
      mpc      = RST_PC;
      started  = 1;
      just_rst = 1;
    end else if (started) begin
      just_rst = 0;
      m_deq = (mq.size() != 0) && bus.out_ready;
      m_enq = bus.fetch_en && !bus.redirect_valid && ((mq.size() < DEPTH) || m_deq);
      if (m_deq) void'(mq.pop_front());
      if (bus.redirect_valid) begin
        mq.delete();
        mpc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else if (m_enq) begin
        mq.push_back('{pc: mpc, instr: rom_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rom_addr", bus.rom_addr, mpc);
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      if (mq.size() != 0) begin
        chk("out_pc", bus.out_pc, mq[0].pc);
        chk("out_instr", bus.out_instr, mq[0].instr);
        chk("out_pc4", bus.out_pc4, mq[0].pc + 32'd4);
      end else if (just_rst) begin
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_pc4", bus.out_pc4, 32'h0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset              = 1'b1;
    bus.fetch_en       = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step(2);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_addr", bus.rom_addr, 32'h0);
    chk("rst_pc4", bus.out_pc4, 32'h0);

    // Streaming from reset
    reset = 1'b0;
    chk("t1_addr0", bus.rom_addr, 32'h0);
    step(1);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_pc0", bus.out_pc, 32'h0);
    chk("t1_instr0", bus.out_instr, rom_word(32'h0));
    chk("t1_addr4", bus.rom_addr, 32'h4);
    chk("t1_pc4", bus.out_pc4, 32'h4);
    step(1);
    chk("t1_pc1", bus.out_pc, 32'h4);
    chk("t1_addr8", bus.rom_addr, 32'h8);
    step(5);

    // Back-pressure
    do_reset();
    bus.out_ready = 1'b0;
    step(10);
    chk("t2_count", 32'(bus.fifo_count), 32'd4);
    chk("t2_addr", bus.rom_addr, 32'h10);
    chk("t2_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    step(1);
    chk("t2_resume_pc", bus.out_pc, 32'h4);
    chk("t2_resume_cnt", 32'(bus.fifo_count), 32'd4);
    step(6);

    // Redirect while full
    bus.out_ready = 1'b0;
    step(6);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0057;
    step(1);
    bus.redirect_valid = 1'b0;
    chk("t3_addr", bus.rom_addr, 32'h54);
    chk("t3_count", 32'(bus.fifo_count), 32'd0);
    chk("t3_valid0", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("t3_valid1", 32'(bus.out_valid), 32'd1);
    chk("t3_pc", bus.out_pc, 32'h54);
    chk("t3_instr", bus.out_instr, rom_word(32'h54));
    bus.out_ready = 1'b1;
    step(4);

    // Redirect coinciding with a handshake on 0x3C
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.out_valid && bus.out_pc == 32'h3C) found = 1;
      else step(1);
    end
    chk("t4_reach_3c", 32'(found), 32'd1);
    if (found) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      step(1);
      bus.redirect_valid = 1'b0;
      chk("t4_valid0", 32'(bus.out_valid), 32'd0);
      step(1);
      chk("t4_pc", bus.out_pc, 32'h200);
      step(3);
    end

    // PC wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    bus.redirect_valid = 1'b0;
    step(1);
    chk("t5_pc_top", bus.out_pc, 32'hFFFF_FFFC);
    chk("t5_pc4_top", bus.out_pc4, 32'h0);
    step(1);
    chk("t5_pc_wrap", bus.out_pc, 32'h0);
    step(1);
    chk("t5_pc_next", bus.out_pc, 32'h4);

    // Reset mid-stream, then halt while draining
    do_reset();
    bus.out_ready = 1'b0;
    step(3);
    chk("t6_count3", 32'(bus.fifo_count), 32'd3);
    reset = 1'b1;
    step(1);
    chk("t6_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("t6_rst_addr", bus.rom_addr, RST_PC);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    step(3);
    chk("t6_refill", 32'(bus.fifo_count), 32'd3);
    chk("t6_addr_c", bus.rom_addr, 32'hC);
    bus.fetch_en  = 1'b0;
    bus.out_ready = 1'b1;
    step(1);
    chk("t6_halt_addr1", bus.rom_addr, 32'hC);
    chk("t6_drain1", 32'(bus.fifo_count), 32'd2);
    step(1);
    chk("t6_halt_addr2", bus.rom_addr, 32'hC);
    chk("t6_drain2", 32'(bus.fifo_count), 32'd1);
    bus.fetch_en = 1'b1;
    step(3);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 199) == 0);
      bus.fetch_en       = ($urandom_range(0, 9) != 0);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
      step(1);
    end
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
